rom_controller: RTL and testbench

- Upstream word source for the dma block.
- Takes a word-address read request (addr + load pulse) and performs two byte reads on the board's 8-bit parallel NOR flash.
- Assembles the bytes into one WIDTH-bit word, then presents it with a one-cycle ready strobe.
- The dma consumes ready as its memory write strobe and data as the write data.

---
 rtl/rom_controller_pkg.sv | 20 ++
 rtl/rom_wait_timer.sv | 38 +++
 rtl/rom_controller.sv | 125 ++++++++++++
 tb/tb_rom_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_controller_pkg.sv
// Shared definitions for the flash word-read controller: state encodings,
// default geometry, and the wait-counter width helper.
package rom_controller_pkg;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_RD_LO = 2'd1,
    RC_RD_HI = 2'd2
  } rc_state_e;

  localparam int RC_ROM_ADDR    = 23;
  localparam int RC_FLASH_ADDR  = 24;
  localparam int RC_WAIT_CYCLES = 4;

  // A single-cycle wait still needs a one-bit counter to exist.
  function automatic int rc_cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/rom_wait_timer.sv
// Loadable down-counter that paces each flash byte access; zero marks the
// edge on which the byte is sampled.
module rom_wait_timer
  import rom_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = RC_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int            CW     = rc_cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/rom_controller.sv
// Fetches one word from an 8-bit NOR flash as two timed byte reads (even
// byte first) and hands it to the dma with a one-cycle ready strobe.
module rom_controller
  import rom_controller_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ROM_ADDR    = RC_ROM_ADDR,
  parameter int FLASH_ADDR  = RC_FLASH_ADDR,
  parameter int WAIT_CYCLES = RC_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROM_ADDR-1:0]   addr,
  input  logic                  load,
  output logic [WIDTH-1:0]      data,
  output logic                  ready,
  output logic                  busy,
  output logic [FLASH_ADDR-1:0] flash_addr,
  input  logic [7:0]            flash_data,
  output logic                  flash_ce_n,
  output logic                  flash_oe_n,
  output logic                  flash_we_n
);

  rc_state_e             state_q, state_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [FLASH_ADDR-1:0] flash_addr_q, flash_addr_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic [7:0]            lo_q, lo_d;
  logic                  timer_load;
  logic                  timer_zero;

  rom_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .zero (timer_zero)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    ready_d      = 1'b0;
    flash_addr_d = flash_addr_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    lo_d         = lo_q;
    timer_load   = 1'b0;

    unique case (state_q)
      RC_IDLE: begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        if (load) begin
          flash_addr_d = FLASH_ADDR'({addr, 1'b0});
          ce_n_d       = 1'b0;
          oe_n_d       = 1'b0;
          timer_load   = 1'b1;
          state_d      = RC_RD_LO;
        end
      end
      RC_RD_LO: begin
        if (timer_zero) begin
          lo_d            = flash_data;
          flash_addr_d[0] = 1'b1;
          timer_load      = 1'b1;
          state_d         = RC_RD_HI;
        end
      end
      RC_RD_HI: begin
        if (timer_zero) begin
          data_d  = WIDTH'({flash_data, lo_q});
          ready_d = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = RC_IDLE;
        end
      end
      default: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        state_d = RC_IDLE;
      end
    endcase

    // Registered so busy lines up exactly with the state it reports.
    busy_d = (state_d != RC_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RC_IDLE;
      data_q       <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      flash_addr_q <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      flash_addr_q <= flash_addr_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      lo_q         <= lo_d;
    end
  end

  assign data       = data_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign flash_addr = flash_addr_q;
  assign flash_ce_n = ce_n_q;
  assign flash_oe_n = oe_n_q;
  assign flash_we_n = 1'b1;

endmodule

// File: tb/tb_rom_controller.sv
// Directed bench for rom_controller: a small flash model answers byte reads,
// and every check is an immediate assertion against a hand-computed value.
module tb_rom_controller;
  import rom_controller_pkg::*;

  localparam int WIDTH = 16;

  logic                     clk;
  logic                     rst;
  logic [RC_ROM_ADDR-1:0]   addr;
  logic                     load;
  logic [WIDTH-1:0]         data;
  logic                     ready;
  logic                     busy;
  logic [RC_FLASH_ADDR-1:0] flash_addr;
  logic [7:0]               flash_data;
  logic                     flash_ce_n;
  logic                     flash_oe_n;
  logic                     flash_we_n;

  int n_vec;
  int n_fail;

  rom_controller #(
    .WIDTH      (WIDTH),
    .ROM_ADDR   (RC_ROM_ADDR),
    .FLASH_ADDR (RC_FLASH_ADDR),
    .WAIT_CYCLES(RC_WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .load      (load),
    .data      (data),
    .ready     (ready),
    .busy      (busy),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input logic [RC_FLASH_ADDR-1:0] a);
    case (a)
      24'h000246: return 8'h34;
      24'h000247: return 8'h12;
      24'h000A00: return 8'h77;
      24'h000A01: return 8'h66;
      24'h000020: return 8'hAA;
      24'h000021: return 8'hBB;
      24'h000022: return 8'hCC;
      24'h000023: return 8'hDD;
      24'hFFFFFE: return 8'h5A;
      24'hFFFFFF: return 8'hC3;
      default:    return a[7:0] ^ 8'h96;
    endcase
  endfunction

  // Bus floats high unless the part is selected and output-enabled.
  always_comb begin
    flash_data = 8'hFF;
    if (!flash_ce_n && !flash_oe_n) flash_data = flash_byte(flash_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word read; optionally fires a stray load (addr 0x500) mid-read.
  task automatic read_word(input logic [RC_ROM_ADDR-1:0] a, input logic [15:0] exp,
                           input bit stray);
    addr = a;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    addr = '0;
    for (int c = 0; c < 8; c++) begin
      chk("flash_addr", 32'({a, (c >= 4) ? 1'b1 : 1'b0}), 32'(flash_addr));
      chk("ready_low", 32'(ready), 32'(1'b0));
      chk("busy_high", 32'(busy), 32'(1'b1));
      chk("oe_n_low", 32'(flash_oe_n), 32'(1'b0));
      if (stray && c == 2) begin
        load = 1'b1;
        addr = 23'h000500;
      end else if (stray && c == 3) begin
        load = 1'b0;
        addr = '0;
      end
      @(negedge clk);
    end
    chk("ready_pulse", 32'(ready), 32'(1'b1));
    chk("data", 32'(data), 32'(exp));
    chk("busy_done", 32'(busy), 32'(1'b0));
    chk("ce_n_done", 32'(flash_ce_n), 32'(1'b1));
    chk("oe_n_done", 32'(flash_oe_n), 32'(1'b1));
    @(negedge clk);
    chk("ready_drop", 32'(ready), 32'(1'b0));
    chk("data_hold", 32'(data), 32'(exp));
    chk("flash_addr_hold", 32'(flash_addr), 32'({a, 1'b1}));
    $display("read addr=%06h data=%04h", a, data);
  endtask

  initial begin
    int r1;
    int r2;
    logic [15:0] d1;
    logic [15:0] d2;

    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b1;
    load   = 1'b0;
    addr   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_faddr", 32'(flash_addr), 32'h0);
    chk("rst_ce_n", 32'(flash_ce_n), 32'h1);
    chk("rst_oe_n", 32'(flash_oe_n), 32'h1);
    chk("rst_we_n", 32'(flash_we_n), 32'h1);
    $display("reset state checked");

    // Single read
    read_word(23'h000123, 16'h1234, 1'b0);

    // Load while busy is ignored and not queued
    read_word(23'h000123, 16'h1234, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("no_queued_ready", 32'(ready), 32'h0);
      chk("no_queued_busy", 32'(busy), 32'h0);
      @(negedge clk);
    end
    $display("stray load ignored");

    // load held high: back-to-back reads 9 cycles apart
    addr = 23'h000010;
    load = 1'b1;
    @(negedge clk);
    addr = 23'h000011;
    r1 = -1;
    r2 = -1;
    d1 = '0;
    d2 = '0;
    for (int c = 0; c < 40 && r2 < 0; c++) begin
      if (ready) begin
        if (r1 < 0) begin
          r1 = c;
          d1 = data;
        end else begin
          r2 = c;
          d2 = data;
          load = 1'b0;
        end
      end
      if (r2 < 0) @(negedge clk);
    end
    load = 1'b0;
    chk("b2b_first_lat", 32'(r1), 32'd8);
    chk("b2b_second_lat", 32'(r2), 32'd17);
    chk("b2b_first_data", 32'(d1), 32'h0000BBAA);
    chk("b2b_second_data", 32'(d2), 32'h0000DDCC);
    @(negedge clk);
    chk("b2b_idle_after", 32'(busy), 32'h0);
    $display("back-to-back ready at %0d and %0d data %04h %04h", r1, r2, d1, d2);

    // Top of the address space
    read_word(23'h7FFFFF, 16'hC35A, 1'b0);

    // Reset asserted in RD_HI, between clock edges
    addr = 23'h000123;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_faddr", 32'(flash_addr), 32'h000247);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ce_n", 32'(flash_ce_n), 32'h1);
    chk("async_oe_n", 32'(flash_oe_n), 32'h1);
    chk("async_we_n", 32'(flash_we_n), 32'h1);
    chk("async_ready", 32'(ready), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_data", 32'(data), 32'h0);
    chk("async_faddr", 32'(flash_addr), 32'h0);
    $display("async reset mid-read checked");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_no_ready", 32'(ready), 32'h0);
      @(negedge clk);
    end
    read_word(23'h000123, 16'h1234, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
